sipo_deframer: RTL and testbench
================================

Name: sipo_deframer

Overview:
- Serial-to-parallel front end that feeds the downstream 4-bit parallel-in/parallel-out register stage.
- Extracts framed words from a 1-bit serial line: one start bit (0), WIDTH data bits, one stop bit (1).
- Presents each good word on a held parallel bus with a valid/ack handshake.
- Flags framing errors and overruns.

Parameters:
- WIDTH, 4, data bits per frame and parallel output width (WIDTH >= 1).
- LSB_FIRST, 1, 1: first data bit received lands in bit 0; 0: first data bit received lands in bit WIDTH-1.

Ports:
- clk  input  1  system clock; all state changes on posedge clk.
- rst  input  1  synchronous, active-high reset.
- bit_en  input  1  bit-time strobe; sin is sampled and the FSM advances only on cycles with bit_en=1.
- sin  input  1  serial data line; idles at 1.
- data_ack  input  1  consumer has taken data_out; meaningful only while data_valid=1.
- data_out  output  WIDTH  last good received word; held stable while data_valid=1.
- data_valid  output  1  data_out holds an unconsumed word.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- overrun  output  1  sticky flag: a good word was dropped because the previous word was not consumed.

Behaviour:
- Reset: rst=1 at posedge clk gives the following state:
  - state=IDLE, bit counter=0, shift register=0.
  - data_out=0, data_valid=0, frame_err=0, overrun=0.
  - rst has priority over every other input.
  - rst mid-frame aborts the frame; no word and no flag is produced.
- Bit counter width is $clog2(WIDTH+1). The shift register is WIDTH bits and internal.
- FSM states IDLE, DATA, STOP. On cycles with bit_en=0, FSM, counter and shift register hold.
- IDLE:
  - bit_en=1 and sin=0 (start bit): go to DATA, counter=0.
  - sin=1: stay in IDLE.
- DATA, on each bit_en=1:
  - Shift in sin. LSB_FIRST=1: shift right, insert at MSB, so after WIDTH bits the first bit is in bit 0. LSB_FIRST=0: shift left, insert at LSB.
  - Increment the counter. On the WIDTH-th bit, go to STOP.
- STOP, on bit_en=1 (always returns to IDLE afterwards):
  - sin=1, and data_valid=0 or data_ack=1 this cycle: data_out <= shift register, data_valid <= 1.
  - sin=1, data_valid=1 and data_ack=0: word dropped, data_out unchanged, overrun <= 1.
  - sin=0: frame_err=1 for exactly one cycle, word discarded, data_out and data_valid unaffected by the frame.
- Latency: data_valid/data_out update at the posedge that samples the stop bit, i.e. visible in the cycle after the stop-bit bit_en cycle.
- Handshake:
  - data_valid=1 and data_ack=1 with no load in the same cycle: data_valid <= 0 next cycle. data_out keeps its last value.
  - Load and ack in the same cycle: data_valid stays 1 and data_out takes the new word (no bubble, no overrun).
  - data_ack while data_valid=0 is ignored.
- overrun stays 1 until rst; it does not block further receptions.
- frame_err is 0 on every cycle except the stop-bit-error cycle.
- Back-to-back frames: a start bit may arrive on the bit_en immediately after the stop bit.
- Consecutive bit_en cycles (bit_en held at 1) are legal.

Test Plan:
- Reset, then bit_en every 4th cycle, sin = 0,1,0,1,1,1 (start, d=1,0,1,1, stop), LSB_FIRST=1 -> after the stop sample, data_out=4'hD, data_valid=1, frame_err=0, overrun=0.
- Same bit sequence with LSB_FIRST=0 -> data_out=4'hB.
- Frame 0,1,1,1,1,0 (bad stop) -> frame_err pulses for exactly 1 cycle; data_valid stays 0; the next good frame 0,0,0,0,1,1 gives data_out=4'h8.
- Two good frames 4'h3 then 4'hC with data_ack held 0 -> data_out stays 4'h3, data_valid=1, overrun=1. Then pulse data_ack -> data_valid=0 next cycle, overrun still 1.
- data_ack asserted on the same cycle the second word (4'hC) loads -> data_valid remains 1, data_out=4'hC, overrun=0.
- Assert rst after 2 data bits of a frame, then deassert with sin=1 idle -> no data_valid, no frame_err; a following good frame 4'h5 is received correctly (start detection is not corrupted).

Source files
------------

// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer: start bit, WIDTH data bits, stop bit in; held parallel word out
// with a valid/ack handshake, a one-cycle framing-error pulse and a sticky overrun flag.
module sipo_deframer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             sin,
    input  logic             data_ack,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             frame_err,
    output logic             overrun
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_e;

    state_e             state_q,      state_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [WIDTH-1:0]   shreg_q,      shreg_d;
    logic [WIDTH-1:0]   data_out_q,   data_out_d;
    logic               data_valid_q, data_valid_d;
    logic               frame_err_q,  frame_err_d;
    logic               overrun_q,    overrun_d;

    logic [WIDTH-1:0]   shift_in;

    // Shift operators instead of slices keep WIDTH=1 legal.
    always_comb begin
        if (LSB_FIRST) begin
            shift_in = (shreg_q >> 1) | (WIDTH'(sin) << (WIDTH - 1));
        end else begin
            shift_in = (shreg_q << 1) | WIDTH'(sin);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = overrun_q;

        if (data_valid_q && data_ack) begin
            data_valid_d = 1'b0;
        end

        if (bit_en) begin
            unique case (state_q)
                IDLE: begin
                    if (!sin) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shreg_d = shift_in;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    state_d = IDLE;
                    if (!sin) begin
                        frame_err_d = 1'b1;
                    end else if (!data_valid_q || data_ack) begin
                        // A load in the same cycle as an ack wins: no bubble.
                        data_out_d   = shreg_q;
                        data_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_deframer.sv
// Directed bench for sipo_deframer: two instances (LSB-first and MSB-first) share one serial stimulus;
// expected words are queued as frames are sent and popped when the load is due.
module tb_sipo_deframer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_en;
    logic         sin;
    logic         data_ack;
    logic [W-1:0] dout_l, dout_m;
    logic         dv_l, dv_m, fe_l, fe_m, ov_l, ov_m;

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] m;
    } exp_t;

    exp_t sb[$];
    int   total   = 0;
    int   passed  = 0;
    int   fails   = 0;
    int   fe_cnt  = 0;

    always #5 clk = ~clk;

    sipo_deframer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin), .data_ack(data_ack),
        .data_out(dout_l), .data_valid(dv_l), .frame_err(fe_l), .overrun(ov_l)
    );

    sipo_deframer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin), .data_ack(data_ack),
        .data_out(dout_m), .data_valid(dv_m), .frame_err(fe_m), .overrun(ov_m)
    );

    // Counts every cycle either instance shows frame_err high.
    always @(negedge clk) begin
        if (fe_l === 1'b1) fe_cnt++;
        if (fe_m === 1'b1) fe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        sin    = b;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        repeat (gap) tick();
    endtask

    // d[i] is the i-th transmitted data bit; returns right after the stop-bit sample.
    task automatic send_frame(input logic [W-1:0] d, input logic stop, input int gap, input logic ack_stop);
        send_bit(1'b0, gap);
        for (int i = 0; i < int'(W); i++) send_bit(d[i], gap);
        sin    = stop;
        bit_en = 1'b1;
        if (ack_stop) data_ack = 1'b1;
        tick();
        bit_en = 1'b0;
        sin    = 1'b1;
        if (ack_stop) data_ack = 1'b0;
    endtask

    task automatic expect_word(input logic [W-1:0] l, input logic [W-1:0] m);
        exp_t e;
        e.l = l;
        e.m = m;
        sb.push_back(e);
    endtask

    task automatic check_word(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            fails++;
            $error("FAIL %s_sb: observed empty queue expected one word", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_lsb_data"}, 32'(dout_l), 32'(e.l));
            chk({tag, "_msb_data"}, 32'(dout_m), 32'(e.m));
            chk({tag, "_lsb_valid"}, 32'(dv_l), 32'd1);
            chk({tag, "_msb_valid"}, 32'(dv_m), 32'd1);
        end
    endtask

    task automatic pulse_ack();
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int fe0;
        rst      = 1'b1;
        bit_en   = 1'b0;
        sin      = 1'b1;
        data_ack = 1'b0;

        // Reset state
        do_reset();
        chk("rst_data",    32'(dout_l), 32'd0);
        chk("rst_valid",   32'(dv_l | dv_m), 32'd0);
        chk("rst_ferr",    32'(fe_l | fe_m), 32'd0);
        chk("rst_overrun", 32'(ov_l | ov_m), 32'd0);

        // Good frame 1,0,1,1
        expect_word(4'hD, 4'hB);
        send_frame(4'hD, 1'b1, 3, 1'b0);
        check_word("frame_d");
        chk("frame_d_ferr",    32'(fe_l | fe_m), 32'd0);
        chk("frame_d_overrun", 32'(ov_l | ov_m), 32'd0);
        repeat (3) tick();
        pulse_ack();
        chk("ack_valid_l", 32'(dv_l), 32'd0);
        chk("ack_valid_m", 32'(dv_m), 32'd0);
        chk("ack_hold_l",  32'(dout_l), 32'hD);
        pulse_ack();
        chk("ack_idle_valid", 32'(dv_l | dv_m), 32'd0);

        // Bad stop bit, then good frame 0,0,0,1
        fe0 = fe_cnt;
        send_frame(4'hF, 1'b0, 3, 1'b0);
        chk("bad_ferr_l", 32'(fe_l), 32'd1);
        chk("bad_ferr_m", 32'(fe_m), 32'd1);
        repeat (3) tick();
        chk("bad_ferr_width", 32'(fe_cnt - fe0), 32'd2);
        chk("bad_valid",      32'(dv_l | dv_m), 32'd0);
        chk("bad_data_hold",  32'(dout_l), 32'hD);
        expect_word(4'h8, 4'h1);
        send_frame(4'h8, 1'b1, 3, 1'b0);
        check_word("frame_8");
        repeat (3) tick();
        pulse_ack();

        // Overrun: second word dropped while first unconsumed
        expect_word(4'h3, 4'hC);
        send_frame(4'h3, 1'b1, 3, 1'b0);
        check_word("ovr_first");
        chk("ovr_first_flag", 32'(ov_l | ov_m), 32'd0);
        repeat (3) tick();
        send_frame(4'hC, 1'b1, 3, 1'b0);
        chk("ovr_hold_l", 32'(dout_l), 32'h3);
        chk("ovr_hold_m", 32'(dout_m), 32'hC);
        chk("ovr_valid",  32'(dv_l & dv_m), 32'd1);
        chk("ovr_flag_l", 32'(ov_l), 32'd1);
        chk("ovr_flag_m", 32'(ov_m), 32'd1);
        repeat (3) tick();
        pulse_ack();
        chk("ovr_ack_valid", 32'(dv_l | dv_m), 32'd0);
        chk("ovr_sticky",    32'(ov_l & ov_m), 32'd1);

        // Load and ack in the same cycle: no bubble, no overrun
        do_reset();
        chk("rst2_overrun", 32'(ov_l | ov_m), 32'd0);
        expect_word(4'h3, 4'hC);
        send_frame(4'h3, 1'b1, 3, 1'b0);
        check_word("same_first");
        repeat (3) tick();
        expect_word(4'hC, 4'h3);
        send_frame(4'hC, 1'b1, 3, 1'b1);
        check_word("same_second");
        chk("same_overrun", 32'(ov_l | ov_m), 32'd0);
        repeat (3) tick();
        chk("same_still_valid", 32'(dv_l & dv_m), 32'd1);
        pulse_ack();

        // Reset mid-frame after two data bits
        fe0 = fe_cnt;
        send_bit(1'b0, 3);
        send_bit(1'b1, 3);
        send_bit(1'b0, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) send_bit(1'b1, 3);
        chk("abort_valid", 32'(dv_l | dv_m), 32'd0);
        chk("abort_ferr",  32'(fe_cnt - fe0), 32'd0);
        chk("abort_data",  32'(dout_l | dout_m), 32'd0);
        expect_word(4'h5, 4'hA);
        send_frame(4'h5, 1'b1, 3, 1'b0);
        check_word("after_abort");
        repeat (3) tick();
        pulse_ack();

        // Back-to-back frames with bit_en held high and ack held high
        data_ack = 1'b1;
        expect_word(4'hE, 4'h7);
        send_frame(4'hE, 1'b1, 0, 1'b0);
        check_word("b2b_first");
        expect_word(4'h1, 4'h8);
        send_frame(4'h1, 1'b1, 0, 1'b0);
        check_word("b2b_second");
        tick();
        chk("b2b_consumed", 32'(dv_l | dv_m), 32'd0);
        chk("b2b_overrun",  32'(ov_l | ov_m), 32'd0);
        data_ack = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
